// File: rtl/distribute_chain_injector_seq.sv
// Source-side injector for a chain of 1x2 one-hot distribute switches: buffers {dest, data}
// words in a small FIFO and issues one per enabled cycle. Optional macro: DISTRIBUTE_INJECT_DROP_ZERO_EN.
module distribute_chain_injector_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_NODE   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_valid,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic [NUM_NODE-1:0]           i_dest,
  output logic                          o_ready,
  input  logic                          i_en,
  output logic                          o_valid,
  output logic [DATA_WIDTH-1:0]         o_data_bus,
  output logic [NUM_NODE-1:0]           o_cmd,
  output logic                          o_en,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
`ifdef DISTRIBUTE_INJECT_DROP_ZERO_EN
  , output logic [CNT_WIDTH-1:0]        o_drop_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = NUM_NODE + DATA_WIDTH;

  if ((FIFO_DEPTH < 2) || ((1 << PW) != FIFO_DEPTH) || (CNT_WIDTH < 1)) begin : g_param_check
    $error("distribute_chain_injector_seq: FIFO_DEPTH must be a power of two >= 2, CNT_WIDTH >= 1");
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          store;
  logic          pop;
  logic [EW-1:0] rd_entry;

  assign o_ready  = (o_count != CW'(FIFO_DEPTH));
  assign push     = i_valid && o_ready;
  assign pop      = i_en && (o_count != '0);
  assign rd_entry = mem[rd_ptr];

`ifdef DISTRIBUTE_INJECT_DROP_ZERO_EN
  // Zero-mask words complete the handshake but never enter the buffer.
  assign store = push && (i_dest != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_drop_cnt <= '0;
    end else if (push && (i_dest == '0) && (o_drop_cnt != '1)) begin
      o_drop_cnt <= o_drop_cnt + CNT_WIDTH'(1);
    end
  end
`else
  assign store = push;
`endif

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr] <= {i_dest, i_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_count    <= '0;
      o_valid    <= 1'b0;
      o_data_bus <= '0;
      o_cmd      <= '0;
      o_en       <= 1'b0;
    end else begin
      o_en <= i_en;
      if (store) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + PW'(1);
        o_valid    <= 1'b1;
        o_data_bus <= rd_entry[DATA_WIDTH-1:0];
        o_cmd      <= rd_entry[EW-1:DATA_WIDTH];
      end else begin
        o_valid    <= 1'b0;
        o_data_bus <= '0;
        o_cmd      <= '0;
      end
      if (store && !pop) begin
        o_count <= o_count + CW'(1);
      end else if (pop && !store) begin
        o_count <= o_count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_distribute_chain_injector_seq.sv
// Directed self-checking bench for distribute_chain_injector_seq (default parameters).
// Follows DISTRIBUTE_INJECT_DROP_ZERO_EN so it matches the RTL build it is compiled with.
module tb_distribute_chain_injector_seq;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_data;
  logic [3:0]  i_dest;
  logic        o_ready;
  logic        i_en;
  logic        o_valid;
  logic [31:0] o_data_bus;
  logic [3:0]  o_cmd;
  logic        o_en;
  logic [2:0]  o_count;
`ifdef DISTRIBUTE_INJECT_DROP_ZERO_EN
  logic [15:0] o_drop_cnt;
`endif

  int checks = 0;
  int failures = 0;

  distribute_chain_injector_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .i_dest     (i_dest),
    .o_ready    (o_ready),
    .i_en       (i_en),
    .o_valid    (o_valid),
    .o_data_bus (o_data_bus),
    .o_cmd      (o_cmd),
    .o_en       (o_en),
    .o_count    (o_count)
`ifdef DISTRIBUTE_INJECT_DROP_ZERO_EN
    , .o_drop_cnt (o_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge; outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_dest = '0; i_en = 1'b0;
    #12;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", o_valid); end
    checks++; if (o_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", o_count); end
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", o_ready); end
    checks++; if (o_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%0b exp=0", o_en); end
`ifdef DISTRIBUTE_INJECT_DROP_ZERO_EN
    checks++; if (o_drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", o_drop_cnt); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    i_valid = 1'b1; i_data = 32'hA5A5_0001; i_dest = 4'b0101; i_en = 1'b1;
    step();
    i_valid = 1'b0;
    checks++; if (o_count !== 3'd1) begin failures++; $display("FAIL single_count_in got=%0d exp=1", o_count); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL single_no_bypass got=%0b exp=0", o_valid); end
    step();
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", o_valid); end
    checks++; if (o_cmd !== 4'b0101) begin failures++; $display("FAIL single_cmd got=%b exp=0101", o_cmd); end
    checks++; if (o_data_bus !== 32'hA5A5_0001) begin failures++; $display("FAIL single_data got=%h exp=a5a50001", o_data_bus); end
    checks++; if (o_en !== 1'b1) begin failures++; $display("FAIL single_en got=%0b exp=1", o_en); end
    checks++; if (o_count !== 3'd0) begin failures++; $display("FAIL single_count_out got=%0d exp=0", o_count); end
    step();
    checks++; if ({o_valid, o_data_bus, o_cmd} !== 37'd0) begin failures++; $display("FAIL single_zero got=%0b/%h/%b exp=0/0/0", o_valid, o_data_bus, o_cmd); end
  endtask

  task automatic test_fill();
    i_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; i_data = 32'h10 + i; i_dest = 4'(i + 1);
      step();
    end
    checks++; if (o_count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", o_count); end
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL fill_ready got=%0b exp=0", o_ready); end
    checks++; if (o_en !== 1'b0) begin failures++; $display("FAIL fill_en got=%0b exp=0", o_en); end
    i_data = 32'h99; i_dest = 4'b1111;
    step();
    checks++; if (o_count !== 3'd4) begin failures++; $display("FAIL fill_overflow_count got=%0d exp=4", o_count); end
    i_valid = 1'b0; i_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (o_valid !== 1'b1 || o_data_bus !== 32'h10 + i || o_cmd !== 4'(i + 1)) begin
        failures++; $display("FAIL fill_drain_%0d got=%0b/%h/%b exp=1/%h/%b", i, o_valid, o_data_bus, o_cmd, 32'h10 + i, 4'(i + 1));
      end
      if (i == 0) begin
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_rise got=%0b exp=1", o_ready); end
      end
    end
    step();
    checks++; if (o_valid !== 1'b0 || o_count !== 3'd0) begin failures++; $display("FAIL fill_empty got=%0b/%0d exp=0/0", o_valid, o_count); end
  endtask

  task automatic test_back_to_back();
    i_en = 1'b1; i_dest = 4'b1000;
    for (int k = 0; k <= 16; k++) begin
      i_valid = (k < 16); i_data = 32'(k);
      step();
      if (k >= 1) begin
        checks++; if (o_valid !== 1'b1 || o_data_bus !== 32'(k - 1) || o_cmd !== 4'b1000) begin
          failures++; $display("FAIL stream_%0d got=%0b/%h/%b exp=1/%h/1000", k, o_valid, o_data_bus, o_cmd, 32'(k - 1));
        end
      end
      checks++; if (o_count !== ((k < 16) ? 3'd1 : 3'd0)) begin
        failures++; $display("FAIL stream_count_%0d got=%0d exp=%0d", k, o_count, (k < 16) ? 1 : 0);
      end
    end
    i_valid = 1'b0;
    step();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL stream_tail got=%0b exp=0", o_valid); end
  endtask

  task automatic test_wrap();
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic prev_en;
    while (got < 10 && cyc < 100) begin
      i_en = (cyc % 2 == 0);
      i_valid = (sent < 10);
      i_data = 32'h100 + sent;
      i_dest = 4'(sent % 15 + 1);
      prev_en = i_en;
      if (i_valid && o_ready) sent++;
      step();
      cyc++;
      checks++; if (o_en !== prev_en) begin failures++; $display("FAIL wrap_en_%0d got=%0b exp=%0b", cyc, o_en, prev_en); end
      if (o_valid === 1'b1) begin
        checks++; if (o_data_bus !== 32'h100 + got || o_cmd !== 4'(got % 15 + 1)) begin
          failures++; $display("FAIL wrap_word_%0d got=%h/%b exp=%h/%b", got, o_data_bus, o_cmd, 32'h100 + got, 4'(got % 15 + 1));
        end
        got++;
      end
    end
    checks++; if (got != 10) begin failures++; $display("FAIL wrap_timeout got=%0d exp=10", got); end
    i_valid = 1'b0; i_en = 1'b1;
    step();
    checks++; if (o_valid !== 1'b0 || o_count !== 3'd0) begin failures++; $display("FAIL wrap_extra got=%0b/%0d exp=0/0", o_valid, o_count); end
  endtask

  task automatic test_zero_mask();
    logic [31:0] exp_d [3];
    logic [3:0]  exp_c [3];
    int n_exp;
`ifdef DISTRIBUTE_INJECT_DROP_ZERO_EN
    n_exp = 2;
    exp_d[0] = 32'h1; exp_c[0] = 4'b0001; exp_d[1] = 32'h2; exp_c[1] = 4'b0010;
`else
    n_exp = 3;
    exp_d[0] = 32'h1; exp_c[0] = 4'b0001; exp_d[1] = 32'hDEAD; exp_c[1] = 4'b0000;
    exp_d[2] = 32'h2; exp_c[2] = 4'b0010;
`endif
    i_en = 1'b0;
    i_valid = 1'b1; i_data = 32'h1; i_dest = 4'b0001; step();
    i_data = 32'hDEAD; i_dest = 4'b0000; step();
    i_data = 32'h2; i_dest = 4'b0010; step();
    i_valid = 1'b0;
    checks++; if (o_count !== 3'(n_exp)) begin failures++; $display("FAIL zero_count got=%0d exp=%0d", o_count, n_exp); end
`ifdef DISTRIBUTE_INJECT_DROP_ZERO_EN
    checks++; if (o_drop_cnt !== 16'd1) begin failures++; $display("FAIL zero_drop got=%0d exp=1", o_drop_cnt); end
`endif
    i_en = 1'b1;
    for (int i = 0; i < n_exp; i++) begin
      step();
      checks++; if (o_valid !== 1'b1 || o_data_bus !== exp_d[i] || o_cmd !== exp_c[i]) begin
        failures++; $display("FAIL zero_word_%0d got=%0b/%h/%b exp=1/%h/%b", i, o_valid, o_data_bus, o_cmd, exp_d[i], exp_c[i]);
      end
    end
    step();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL zero_tail got=%0b exp=0", o_valid); end
  endtask

  task automatic test_async_reset();
    i_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; i_data = 32'h200 + i; i_dest = 4'b0100; step();
    end
    i_valid = 1'b0; i_en = 1'b1;
    step();
    checks++; if (o_valid !== 1'b1 || o_count !== 3'd3) begin failures++; $display("FAIL areset_pre got=%0b/%0d exp=1/3", o_valid, o_count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({o_valid, o_data_bus, o_cmd, o_en} !== 38'd0) begin
      failures++; $display("FAIL areset_outputs got=%0b/%h/%b/%0b exp=0/0/0/0", o_valid, o_data_bus, o_cmd, o_en);
    end
    checks++; if (o_count !== 3'd0 || o_ready !== 1'b1) begin failures++; $display("FAIL areset_count got=%0d/%0b exp=0/1", o_count, o_ready); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (o_valid !== 1'b0 || o_count !== 3'd0) begin failures++; $display("FAIL areset_stale_%0d got=%0b/%0d exp=0/0", i, o_valid, o_count); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_wrap();
    test_zero_mask();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/distribute_chain_injector_seq.md
# distribute_chain_injector_seq

Source-side injector for a chain of 1x2 one-hot distribute switches. It accepts data words, each with a per-node destination bitmask, from a valid/ready producer and buffers them in a small FIFO. When the chain is enabled it issues one word per cycle to the head switch, with the bitmask as the chain command. Each downstream switch consumes the command LSB, so bit k of the mask selects the node behind switch k.

## Interface
Parameters:
- DATA_WIDTH, 32, width of one data word.
- NUM_NODE, 4, number of switches/nodes on the chain; width of the destination mask and of o_cmd.
- FIFO_DEPTH, 4, buffer entries; power of two, at least 2.
- CNT_WIDTH, 16, width of the drop counter (only with the macro defined).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  producer has a word.
- i_data  input  DATA_WIDTH  producer data.
- i_dest  input  NUM_NODE  destination bitmask; bit k is node k, bit 0 is the first switch.
- o_ready  output  1  injector can accept a word this cycle.
- i_en  input  1  chain enable; the head switch may take a word this cycle.
- o_valid  output  1  word valid to the head switch (its i_valid).
- o_data_bus  output  DATA_WIDTH  word to the head switch (its i_data_bus).
- o_cmd  output  NUM_NODE  command to the head switch (its i_cmd).
- o_en  output  1  registered copy of i_en, for the head switch i_en.
- o_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- o_drop_cnt  output  CNT_WIDTH  zero-mask words discarded (only with the macro defined).

## Operation
- Storage: FIFO_DEPTH entries of {i_dest, i_data}.
  - Write pointer and read pointer are each $clog2(FIFO_DEPTH) bits and wrap naturally.
  - The occupancy counter is held separately and drives o_count.
- o_ready = (o_count != FIFO_DEPTH). It is combinational from the counter only and does not depend on i_valid.
- Enqueue when i_valid && o_ready: write the entry at the write pointer, then increment the write pointer.
- Dequeue when i_en && o_count != 0: load the output registers from the read-pointer entry, then increment the read pointer.
  - o_valid <= 1, o_data_bus <= data, o_cmd <= mask.
- No dequeue in a cycle: o_valid <= 0, o_data_bus <= 0, o_cmd <= 0. Dummy data is always all-zero.
- Simultaneous enqueue and dequeue: o_count is unchanged and both pointers advance.
- No bypass: a word enqueued at edge E cannot be dequeued at the same edge E.
- Full: o_ready is low, so the producer's i_valid is ignored and nothing is lost. A dequeue in the same cycle frees a slot, and o_ready rises in the next cycle.
- Empty with i_en high: the outputs return to zero and nothing is popped.
- Reset (asserted at any time, including mid-transfer):
  - o_valid, o_data_bus, o_cmd, o_en, pointers, o_count and o_drop_cnt all go to 0.
  - Buffered words are discarded. o_ready is 1 immediately after reset.
- No protocol state machine. Behaviour is fully determined by occupancy: EMPTY (0), PARTIAL, and FULL (FIFO_DEPTH).

## Timing
- Accept-to-issue latency: a word accepted at edge E into an empty FIFO drives o_valid=1 after edge E+1, provided i_en=1 in the cycle before E+1.
- Throughput: one word per cycle in and one out, sustained, at any occupancy from 1 to FIFO_DEPTH-1.
- o_en follows i_en by exactly one cycle, so o_en is aligned with the o_valid/o_data_bus/o_cmd issued under it.
- Word k of a node-side stream reaches the node output k+1 cycles after issue, because each switch adds one register stage.

## Configuration
- Macro: DISTRIBUTE_INJECT_DROP_ZERO_EN.
- Defined:
  - A handshake with i_dest == 0 (i_valid && o_ready) is accepted but not stored; no pointer or o_count change.
  - o_drop_cnt increments by 1 and saturates at all-ones.
- Undefined:
  - Zero-mask words are stored and issued like any other word. They traverse the chain and are delivered to no node.
  - The o_drop_cnt port does not exist.

## Test plan
- Reset, then single word i_data=0xA5A5_0001, i_dest=4'b0101, i_en=1 -> o_valid=1 with o_cmd=4'b0101 and o_data_bus=0xA5A5_0001 one cycle after acceptance; zero outputs the following cycle; o_count returns to 0.
- Fill with i_en=0: 4 words 0x10..0x13 -> o_count=4, o_ready=0; a 5th offered word is not accepted. Then i_en=1 -> 0x10..0x13 issued in order on 4 consecutive cycles, and o_ready rises the cycle after the first pop.
- Streaming with i_valid=1 and i_en=1 for 16 cycles, data 0..15 -> o_count stays at 1 and outputs are 0..15 back-to-back with no bubbles.
- Pointer wrap: 10 words pushed with i_en toggling 1,0,1,0… -> output order is preserved across wrap; no duplicates or losses.
- i_dest=0 word 0xDEAD between two valid words -> with the macro defined, o_drop_cnt=1 and only the two valid words are issued; without it, three words are issued, the middle one with o_cmd=0.
- rst_n pulsed low asynchronously (mid-cycle) with 3 words buffered and o_valid=1 -> all outputs 0 immediately, o_count=0, o_ready=1; nothing stale is issued after release.
